mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) data memory arbiter with bounded bursts.
// Ports: CLK/reset_n (sync, active-low); cpu_*/dma_* request side
// (req, we, addr, wdata, gnt, rvalid); shared rdata; mem_addr/mem_we/
// mem_din/mem_dout to the data memory; conflict_ct wait-cycle counter.
// Optional macro MEM_ARB_PERF_CNT_EN builds the conflict counter;
// otherwise conflict_ct is tied to zero.
module mem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          cpu_gnt,
   output logic          dma_gnt,
   output logic          cpu_rvalid,
   output logic          dma_rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic [15:0]   conflict_ct
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_CPU = 2'd1,
      OWN_DMA = 2'd2
   } state_t;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   state_t        state_q, state_d, oth_st;
   logic          last_dma_q, last_dma_d;
   logic [3:0]    burst_q, burst_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          cpu_rv_q, cpu_rv_d;
   logic          dma_rv_q, dma_rv_d;
   logic          cpu_gnt_q, cpu_gnt_d;
   logic          dma_gnt_q, dma_gnt_d;
   logic          own_cpu, own_dma;
   logic          own_req, oth_req, own_we;
   logic          burst_last;

   always_comb begin
      own_cpu    = (state_q == OWN_CPU);
      own_dma    = (state_q == OWN_DMA);
      own_req    = (own_cpu & cpu_req) | (own_dma & dma_req);
      oth_req    = (own_cpu & dma_req) | (own_dma & cpu_req);
      own_we     = (own_cpu & cpu_we) | (own_dma & dma_we);
      oth_st     = own_cpu ? OWN_DMA : OWN_CPU;
      burst_last = (burst_q == BURST_LAST);
   end

   // Memory side follows the owner; write is gated by reset so an
   // in-flight write is dropped in the reset cycle itself.
   always_comb begin
      mem_we   = reset_n & own_req & own_we;
      mem_addr = '0;
      mem_din  = '0;
      if (own_cpu) begin
         mem_addr = cpu_addr;
         mem_din  = cpu_wdata;
      end else if (own_dma) begin
         mem_addr = dma_addr;
         mem_din  = dma_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            // Tie goes to whoever was not served last.
            if (cpu_req && (!dma_req || last_dma_q))
               state_d = OWN_CPU;
            else if (dma_req)
               state_d = OWN_DMA;
         end
         OWN_CPU, OWN_DMA: begin
            if (!own_req)
               state_d = oth_req ? oth_st : IDLE;
            else if (burst_last && oth_req)
               state_d = oth_st;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      burst_d = burst_q;
      if (state_d != state_q)
         burst_d = '0;
      else if (own_req)
         burst_d = burst_last ? 4'd0 : burst_q + 4'd1;

      last_dma_d = last_dma_q;
      if (state_d == OWN_CPU) last_dma_d = 1'b0;
      if (state_d == OWN_DMA) last_dma_d = 1'b1;

      cpu_gnt_d = (state_d == OWN_CPU);
      dma_gnt_d = (state_d == OWN_DMA);

      rdata_d  = rdata_q;
      cpu_rv_d = own_req & ~own_we & own_cpu;
      dma_rv_d = own_req & ~own_we & own_dma;
      if (own_req && !own_we)
         rdata_d = mem_dout;
   end

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_dma_q <= 1'b1;
         burst_q    <= '0;
         rdata_q    <= '0;
         cpu_rv_q   <= 1'b0;
         dma_rv_q   <= 1'b0;
         cpu_gnt_q  <= 1'b0;
         dma_gnt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_dma_q <= last_dma_d;
         burst_q    <= burst_d;
         rdata_q    <= rdata_d;
         cpu_rv_q   <= cpu_rv_d;
         dma_rv_q   <= dma_rv_d;
         cpu_gnt_q  <= cpu_gnt_d;
         dma_gnt_q  <= dma_gnt_d;
      end
   end

   assign cpu_gnt    = cpu_gnt_q;
   assign dma_gnt    = dma_gnt_q;
   assign cpu_rvalid = cpu_rv_q;
   assign dma_rvalid = dma_rv_q;
   assign rdata      = rdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [15:0] ct_q, ct_d;
   logic        waiting;

   always_comb begin
      waiting = (cpu_req & ~cpu_gnt_q) | (dma_req & ~dma_gnt_q);
      ct_d    = ct_q + 16'(waiting);
   end

   always_ff @(posedge CLK) begin
      if (!reset_n) ct_q <= '0;
      else          ct_q <= ct_d;
   end

   assign conflict_ct = ct_q;
`else
   assign conflict_ct = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed
// corner sequences, then random traffic against a reference model.
module tb_mem_arbiter;

   localparam int MAXB = 4;

   logic       CLK;
   logic       reset_n;
   logic       cpu_req, cpu_we, dma_req, dma_we;
   logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic       cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
   logic [7:0] rdata, mem_addr, mem_din, mem_dout;
   logic       mem_we;
   logic [15:0] conflict_ct;

   logic [7:0] mem [256];
   assign mem_dout = mem[mem_addr];

   mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
      .CLK(CLK), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .dma_req(dma_req), .dma_we(dma_we),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
      .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .conflict_ct(conflict_ct)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: owner 0=none 1=cpu 2=dma.
   int         m_own, m_last, m_cnt, m_ct;
   logic [7:0] m_rd;
   bit         m_crv, m_drv;
   bit         e_we;
   logic [7:0] e_addr, e_din;

`ifdef MEM_ARB_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_comb();
      e_we   = 0;
      e_addr = 8'h00;
      e_din  = 8'h00;
      if (m_own == 1) begin
         e_we   = reset_n && cpu_req && cpu_we;
         e_addr = cpu_addr;
         e_din  = cpu_wdata;
      end else if (m_own == 2) begin
         e_we   = reset_n && dma_req && dma_we;
         e_addr = dma_addr;
         e_din  = dma_wdata;
      end
   endtask

   task automatic model_step();
      int o, ot, nw;
      bit rq[3];
      bit wq[3];
      logic [7:0] ad[3];
      rq[1] = cpu_req; rq[2] = dma_req;
      wq[1] = cpu_we;  wq[2] = dma_we;
      ad[1] = cpu_addr; ad[2] = dma_addr;
      rq[0] = 0; wq[0] = 0; ad[0] = 0;
      if (!reset_n) begin
         m_own = 0; m_last = 2; m_cnt = 0;
         m_rd = 0; m_crv = 0; m_drv = 0; m_ct = 0;
         return;
      end
      if ((rq[1] && m_own != 1) || (rq[2] && m_own != 2))
         m_ct = (m_ct + 1) % 65536;
      m_crv = 0;
      m_drv = 0;
      o  = m_own;
      nw = o;
      if (o == 0) begin
         if (rq[1] && rq[2]) nw = 3 - m_last;
         else if (rq[1])     nw = 1;
         else if (rq[2])     nw = 2;
      end else begin
         ot = 3 - o;
         if (rq[o]) begin
            m_cnt++;
            if (!wq[o]) begin
               m_rd = mem[ad[o]];
               if (o == 1) m_crv = 1;
               else        m_drv = 1;
            end
            if (m_cnt == MAXB) begin
               m_cnt = 0;
               if (rq[ot]) nw = ot;
            end
         end else begin
            nw = rq[ot] ? ot : 0;
         end
      end
      if (nw != o) m_cnt = 0;
      if (nw != 0) m_last = nw;
      m_own = nw;
   endtask

   // One clock: check memory side before the edge, advance the
   // model and memory at the edge, check registered outputs after.
   task automatic cycle();
      #1;
      model_comb();
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_din", mem_din, e_din);
      @(posedge CLK);
      model_step();
      if (e_we) mem[e_addr] = e_din;
      @(negedge CLK);
      chk("cpu_gnt", cpu_gnt, m_own == 1);
      chk("dma_gnt", dma_gnt, m_own == 2);
      chk("gnt_excl", cpu_gnt & dma_gnt, 0);
      chk("cpu_rvalid", cpu_rvalid, m_crv);
      chk("dma_rvalid", dma_rvalid, m_drv);
      chk("rdata", rdata, m_rd);
      chk("conflict_ct", conflict_ct, PERF ? m_ct : 0);
   endtask

   task automatic idle_in();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
   endtask

   typedef struct {
      bit         rst;
      bit         creq, cwe, dreq, dwe;
      logic [7:0] caddr, daddr;
      bit         x_we, x_cg, x_dg, x_crv, x_drv;
      logic [7:0] x_rd;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int nwr;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3);
      mem[8'h10] = 8'h5A;
      m_own = 0; m_last = 2; m_cnt = 0; m_ct = 0;
      m_rd = 0; m_crv = 0; m_drv = 0;

      //          rst cr cw dr dw caddr  daddr  we cg dg crv drv rd
      tbl[0]  = '{0, 1, 0, 0, 0, 8'h10, 8'h00, 0, 1, 0, 0, 0, 8'h00};
      tbl[1]  = '{0, 1, 0, 0, 0, 8'h10, 8'h00, 0, 1, 0, 1, 0, 8'h5A};
      tbl[2]  = '{0, 0, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0, 8'h5A};
      tbl[3]  = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h5A};
      tbl[4]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};
      tbl[5]  = '{0, 1, 1, 1, 1, 8'h01, 8'h02, 0, 1, 0, 0, 0, 8'h00};
      tbl[6]  = '{0, 1, 1, 1, 1, 8'h01, 8'h02, 1, 1, 0, 0, 0, 8'h00};
      tbl[7]  = '{0, 1, 1, 1, 1, 8'h01, 8'h02, 1, 1, 0, 0, 0, 8'h00};
      tbl[8]  = '{0, 1, 1, 1, 1, 8'h01, 8'h02, 1, 1, 0, 0, 0, 8'h00};
      tbl[9]  = '{0, 1, 1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 0, 0, 8'h00};
      tbl[10] = '{0, 1, 1, 1, 1, 8'h01, 8'h02, 1, 0, 1, 0, 0, 8'h00};
      tbl[11] = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00};

      idle_in();
      reset_n = 0;
      @(negedge CLK);
      cycle();
      cycle();
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ct", conflict_ct, 0);
      reset_n = 1;

      // Vector table: CPU read, then tie after reset with yield.
      for (int i = 0; i < 12; i++) begin
         reset_n   = !tbl[i].rst;
         cpu_req   = tbl[i].creq;
         cpu_we    = tbl[i].cwe;
         cpu_addr  = tbl[i].caddr;
         cpu_wdata = 8'hC1;
         dma_req   = tbl[i].dreq;
         dma_we    = tbl[i].dwe;
         dma_addr  = tbl[i].daddr;
         dma_wdata = 8'hD2;
         #1 chk($sformatf("v%0d_we", i), mem_we, tbl[i].x_we);
         cycle();
         chk($sformatf("v%0d_cg", i), cpu_gnt, tbl[i].x_cg);
         chk($sformatf("v%0d_dg", i), dma_gnt, tbl[i].x_dg);
         chk($sformatf("v%0d_crv", i), cpu_rvalid, tbl[i].x_crv);
         chk($sformatf("v%0d_drv", i), dma_rvalid, tbl[i].x_drv);
         chk($sformatf("v%0d_rd", i), rdata, tbl[i].x_rd);
      end
      reset_n = 1;

      // Handover: CPU drops as DMA raises, no idle gap.
      idle_in();
      cpu_req = 1; cpu_addr = 8'h10;
      cycle();
      chk("ho_cpu_gnt", cpu_gnt, 1);
      cycle();
      chk("ho_rdata", rdata, 8'h5A);
      cpu_req = 0;
      dma_req = 1; dma_we = 1; dma_addr = 8'h33; dma_wdata = 8'h77;
      cycle();
      chk("ho_dma_gnt", dma_gnt, 1);
      chk("ho_cpu_off", cpu_gnt, 0);

      // Reset in the middle of a DMA write.
      reset_n = 0;
      #1 chk("rstw_we_now", mem_we, 0);
      cycle();
      chk("rstw_dma_gnt", dma_gnt, 0);
      chk("rstw_cpu_gnt", cpu_gnt, 0);
      chk("rstw_rdata", rdata, 0);
      #1 chk("rstw_we_after", mem_we, 0);
      reset_n = 1;
      idle_in();
      cycle();

      // DMA burst alone: ten writes, grant never drops.
      nwr = 0;
      dma_req = 1; dma_we = 1; dma_addr = 0;
      cycle();
      chk("bst_gnt0", dma_gnt, 1);
      for (int i = 0; i < 10; i++) begin
         dma_addr  = 8'(i);
         dma_wdata = 8'(8'h30 + i);
         #1 if (mem_we) nwr++;
         cycle();
         chk($sformatf("bst_gnt%0d", i + 1), dma_gnt, 1);
      end
      chk("bst_writes", nwr, 10);
      idle_in();
      cycle();

      // Conflict count: DMA's own idle-cycle wait, then CPU waits 3.
      reset_n = 0;
      cycle();
      reset_n = 1;
      dma_req = 1; dma_addr = 8'h05;
      cycle();
      chk("cf_ct1", conflict_ct, PERF ? 1 : 0);
      cycle();
      cpu_req = 1; cpu_addr = 8'h10;
      cycle();
      cycle();
      cycle();
      chk("cf_cpu_gnt", cpu_gnt, 1);
      chk("cf_ct4", conflict_ct, PERF ? 4 : 0);
      idle_in();
      cycle();

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset_n = ($urandom_range(0, 79) != 0);
         if (cpu_req) cpu_req = ($urandom_range(0, 3) != 0);
         else         cpu_req = ($urandom_range(0, 2) == 0);
         if (dma_req) dma_req = ($urandom_range(0, 3) != 0);
         else         dma_req = ($urandom_range(0, 2) == 0);
         cpu_we    = $urandom_range(0, 1);
         dma_we    = $urandom_range(0, 1);
         cpu_addr  = 8'($urandom);
         dma_addr  = 8'($urandom);
         cpu_wdata = 8'($urandom);
         dma_wdata = 8'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
